// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control, fields and forwarding-resolved
// operands on the falling clock edge, with valid/ready stall, flush bubbles and drain.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [4:0]              rd_i,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [XLEN-1:0]         op1,
  output logic [XLEN-1:0]         op2,
  output logic [XLEN-1:0]         imm_o,
  output logic [2:0]              func3,
  output logic [6:0]              func7,
  output logic [4:0]              rd_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o
);

  // Handshake: a transfer into the buffer happens when in_valid & in_ready; the held
  // entry leaves when out_valid & out_ready. in_ready never depends on in_valid.
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [2:0]        func3_q, func3_d;
  logic [6:0]        func7_q, func7_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;

  logic              load;
  logic [XLEN-1:0]   op1_fwd, op2_fwd;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:0]};

  assign in_ready = out_ready | ~out_valid_q;
  assign load     = in_valid & in_ready;

  // Walk from lowest to highest priority so the lowest matching index wins; x0 reads zero.
  always_comb begin
    op1_fwd = (rs1_addr == 5'd0) ? '0 : rs1_data;
    op2_fwd = (rs2_addr == 5'd0) ? '0 : rs2_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd[5*k +: 5] == rs1_addr) && (rs1_addr != 5'd0))
        op1_fwd = fwd_data[XLEN*k +: XLEN];
      if (fwd_valid[k] && (fwd_rd[5*k +: 5] == rs2_addr) && (rs2_addr != 5'd0))
        op2_fwd = fwd_data[XLEN*k +: XLEN];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    func3_d     = func3_q;
    func7_d     = func7_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
      op1_d       = '0;
      op2_d       = '0;
      imm_d       = '0;
      func3_d     = '0;
      func7_d     = '0;
      rd_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl_i;
      op1_d       = op1_fwd;
      op2_d       = op2_fwd;
      imm_d       = imm_i;
      func3_d     = instr_i[14:12];
      func7_d     = instr_i[31:25];
      rd_d        = rd_i;
      rs1_d       = rs1_addr;
      rs2_d       = rs2_addr;
    end else if (out_ready) begin
      // Drain: retire the entry as a bubble but keep data fields for observability.
      out_valid_d = 1'b0;
      ctrl_d      = '0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      func3_q     <= '0;
      func7_q     <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      func3_q     <= func3_d;
      func7_q     <= func7_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ctrl_o    = ctrl_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign imm_o     = imm_q;
  assign func3     = func3_q;
  assign func7     = func7_q;
  assign rd_o      = rd_q;
  assign rs1_o     = rs1_q;
  assign rs2_o     = rs2_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: table of forwarding vectors plus directed reset,
// stall, flush and drain sequences. State changes on the falling clock edge.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ctrl_i;
  logic [31:0] instr_i;
  logic [31:0] imm_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  ctrl_o;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] imm_o;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;

  int total = 0;
  int bad   = 0;

  id_ex_pipe_reg #(.XLEN(32), .CTRL_W(5), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_i(ctrl_i), .instr_i(instr_i), .imm_i(imm_i), .rd_i(rd_i),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_ready(out_ready), .out_valid(out_valid), .ctrl_o(ctrl_o),
    .op1(op1), .op2(op2), .imm_o(imm_o), .func3(func3), .func7(func7),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [1:0]  fv;
    logic [9:0]  frd;
    logic [63:0] fd;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
  } vec_t;

  vec_t vecs[6];

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] ins, input logic [31:0] im,
                       input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2);
    ctrl_i   = c;
    instr_i  = ins;
    imm_i    = im;
    rd_i     = rd;
    rs1_addr = a1;
    rs2_addr = a2;
    rs1_data = d1;
    rs2_data = d2;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{5'h11, 32'h12345678, 32'h00000100, 5'd1, 5'd5, 5'd6, 32'h33, 32'h66,
                2'b11, {5'd5, 5'd5}, {32'h22, 32'h11}, 32'h11, 32'h66, 3'd5, 7'h09};
    vecs[1] = '{5'h12, 32'hABCDE123, 32'hFFFFFFF0, 5'd2, 5'd5, 5'd6, 32'h33, 32'h66,
                2'b10, {5'd5, 5'd5}, {32'h22, 32'h11}, 32'h22, 32'h66, 3'd6, 7'h55};
    vecs[2] = '{5'h13, 32'h00007000, 32'h00000003, 5'd3, 5'd5, 5'd6, 32'h33, 32'h66,
                2'b00, {5'd5, 5'd5}, {32'h22, 32'h11}, 32'h33, 32'h66, 3'd7, 7'h00};
    vecs[3] = '{5'h14, 32'hFE000000, 32'h00000004, 5'd4, 5'd7, 5'd0, 32'h77, 32'hBEEF,
                2'b01, {5'd7, 5'd0}, {32'h99, 32'hDEAD}, 32'h77, 32'h0, 3'd0, 7'h7F};
    vecs[4] = '{5'h15, 32'h00001000, 32'h00000005, 5'd5, 5'd3, 5'd4, 32'h3, 32'h4,
                2'b11, {5'd4, 5'd3}, {32'h44, 32'h33}, 32'h33, 32'h44, 3'd1, 7'h00};
    vecs[5] = '{5'h16, 32'h02002000, 32'h00000006, 5'd6, 5'd9, 5'd9, 32'h9, 32'h9,
                2'b11, {5'd9, 5'd9}, {32'hA, 32'hB}, 32'hB, 32'hB, 3'd2, 7'h01};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    fwd_valid = 2'b00; fwd_rd = '0; fwd_data = '0;
    drive(5'h1F, 32'hFFFFFFFF, 32'h1234, 5'd31, 5'd1, 5'd2, 32'hAA, 32'hBB);

    // reset held across two edges with an instruction presented
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_func7", func7, 0);
    chk("rst_in_ready", in_ready, 1);

    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_op1", op1, 32'hAA);
    chk("post_rst_rd", rd_o, 31);

    // table-driven forwarding vectors, one load per edge
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].ctrl, vecs[i].instr, vecs[i].imm, vecs[i].rd,
            vecs[i].rs1a, vecs[i].rs2a, vecs[i].rs1d, vecs[i].rs2d);
      fwd_valid = vecs[i].fv;
      fwd_rd    = vecs[i].frd;
      fwd_data  = vecs[i].fd;
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_ctrl", i), ctrl_o, vecs[i].ctrl);
      chk($sformatf("v%0d_op1", i), op1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), op2, vecs[i].e_op2);
      chk($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
      chk($sformatf("v%0d_func3", i), func3, vecs[i].e_f3);
      chk($sformatf("v%0d_func7", i), func7, vecs[i].e_f7);
      chk($sformatf("v%0d_rd", i), rd_o, vecs[i].rd);
      chk($sformatf("v%0d_rs1", i), rs1_o, vecs[i].rs1a);
      chk($sformatf("v%0d_rs2", i), rs2_o, vecs[i].rs2a);
    end
    fwd_valid = 2'b00;

    // stall: A held while B waits three cycles
    drive(5'h15, 32'h00000000, 32'hA0, 5'd10, 5'd1, 5'd2, 32'hA1, 32'hA2);
    tick();
    chk("stall_a_valid", out_valid, 1);
    out_ready = 1'b0;
    drive(5'h0A, 32'h00000000, 32'hB0, 5'd11, 5'd3, 5'd4, 32'hB1, 32'hB2);
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_ctrl", c), ctrl_o, 5'h15);
      chk($sformatf("stall%0d_op1", c), op1, 32'hA1);
      chk($sformatf("stall%0d_rd", c), rd_o, 10);
      chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("b_ctrl", ctrl_o, 5'h0A);
    chk("b_op1", op1, 32'hB1);
    chk("b_rd", rd_o, 11);

    // flush kills held B and the incoming C
    out_ready = 1'b0;
    flush = 1'b1;
    drive(5'h07, 32'h00005000, 32'hC0, 5'd12, 5'd5, 5'd6, 32'hC1, 32'hC2);
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", ctrl_o, 0);
    chk("flush_rd", rd_o, 0);
    chk("flush_op1", op1, 0);
    flush = 1'b0;
    tick();
    chk("after_flush_valid", out_valid, 1);
    chk("after_flush_ctrl", ctrl_o, 5'h07);
    chk("after_flush_op1", op1, 32'hC1);
    chk("after_flush_func3", func3, 5);

    // drain: no new instruction, consumer ready
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_ctrl", ctrl_o, 0);
    chk("drain_op1", op1, 32'hC1);
    chk("drain_rd", rd_o, 12);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the MiniRiscV core, the successor of the fixed five-bit-control decode buffer. It captures decoded control, immediate, instruction fields and operands on each accepted instruction. It resolves operand forwarding internally from NUM_FWD prioritised writeback sources by register-address compare. A valid/ready handshake supports stall, and a flush input inserts bubbles.

Parameters:
XLEN, 32, datapath width of operands, immediate and forwarded data
CTRL_W, 5, width of opaque decoded control bundle (MemRead, MemtoReg, MemWrite, ALUSrc, ALUOp in current core)
NUM_FWD, 2, number of forwarding sources; index 0 highest priority (EX), 1 next (MEM), etc.

Ports:
clk  in  1  pipeline clock; all state updates on falling edge, as the rest of the pipeline does
rst  in  1  synchronous active-low reset, sampled at the falling edge of clk
flush  in  1  kill contents and the incoming instruction (branch/jump redirect)
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  buffer can accept this cycle
ctrl_i  in  CTRL_W  decoded control bundle
instr_i  in  32  raw instruction word
imm_i  in  XLEN  sign-extended immediate
rd_i  in  5  destination register
rs1_addr, rs2_addr  in  5 each  source register addresses
rs1_data, rs2_data  in  XLEN each  register file read data
fwd_valid  in  NUM_FWD  source k will write fwd_data[k] to fwd_rd[k]
fwd_rd  in  5*NUM_FWD  packed destination addresses, source k at [5k+4:5k]
fwd_data  in  XLEN*NUM_FWD  packed data, source k at [XLEN*k+XLEN-1:XLEN*k]
out_ready  in  1  EX stage accepts the held instruction
out_valid  out  1  held instruction is real (not a bubble)
ctrl_o  out  CTRL_W  registered control
op1, op2  out  XLEN each  registered resolved operands
imm_o  out  XLEN  registered immediate
func3  out  3  instr_i[14:12]
func7  out  7  instr_i[31:25]
rd_o, rs1_o, rs2_o  out  5 each  registered addresses (for the hazard unit)

Behaviour:
- Reset (rst==0 at the falling edge): every output register cleared to 0; out_valid=0. Reset dominates flush and load.
- in_ready = out_ready | ~out_valid (combinational; no internal skid entry).
- load = in_valid & in_ready. Latency of one clk edge from the decode side to the outputs.
- Priority at each falling edge: reset > flush > load > hold.
- Flush: out_valid←0; ctrl_o, rd_o←0 (bubble: no memory or register writes); other outputs are don't-care but are cleared to 0 for determinism. The incoming instruction is discarded even if load is high.
- Load: all outputs capture their inputs; out_valid←1.
- Drain: no load and out_ready=1 → out_valid←0 and ctrl_o←0; data fields hold.
- Hold: out_valid=1, out_ready=0 → all outputs unchanged. Stored operands are not re-forwarded; the hazard unit must keep EX/MEM stalled consistently.
- Forwarding per operand j∈{1,2}, evaluated combinationally on the load cycle:
  - Select lowest k with fwd_valid[k] & fwd_rd[k]==rsj_addr & rsj_addr!=0, giving fwd_data[k].
  - If no source matches, use rsj_data.
  - rsj_addr==0 always yields 0, regardless of rsj_data or forwards.
- Both operands may hit the same or different sources in the same cycle; the two resolutions are independent.
- NUM_FWD=1 is legal; NUM_FWD=0 is not supported.
- No arithmetic beyond comparisons; widths pass through unchanged.

Test Plan:
- Reset: hold rst=0 for 2 edges with in_valid=1 → all outputs 0, out_valid=0, in_ready=1; release → next load captures normally.
- Priority forwarding: rs1_addr=5, fwd_valid=2'b11, fwd_rd={5,5}, fwd_data={0x22,0x11} → op1=0x11 (source 0 wins); with fwd_valid=2'b10 → op1=0x22; with fwd_valid=0 and rs1_data=0x33 → op1=0x33.
- x0 guard: rs2_addr=0, fwd_valid=2'b01, fwd_rd[0]=0, fwd_data[0]=0xDEAD, rs2_data=0xBEEF → op2=0.
- Stall: load instr A (out_valid=1), set out_ready=0, then present B for 3 cycles → outputs stay A, in_ready=0; out_ready=1 → B captured next edge.
- Flush: valid A held, flush=1 with in_valid=1 presenting B → out_valid=0, ctrl_o=0, rd_o=0; next edge with flush=0 loads the new instruction.
- Drain: A held, in_valid=0, out_ready=1 → out_valid=0, ctrl_o=0, op1 still equals A's value.
